// File: rtl/fetch_queue.sv
// Instruction fetch queue: FetchPC drives instruction memory; fetched {PC, instr} pairs queue up for decode.
// Latency: fetch-to-head 1 edge on an empty queue, redirect-to-valid 2 edges.
// Backpressure: StallF holds the head; fetch stops when the queue is full with no pop; redirect flushes and overrides both.
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        PCTargetE,
  input  logic                         PCSrcE,
  input  logic                         StallF,
  output logic [DATA_WIDTH-1:0]        ImemAddr,
  input  logic [DATA_WIDTH-1:0]        ImemRdata,
  output logic [DATA_WIDTH-1:0]        InstrF,
  output logic [DATA_WIDTH-1:0]        PCF,
  output logic [DATA_WIDTH-1:0]        PCPlus4F,
  output logic                         ValidF,
  output logic [$clog2(DEPTH+1)-1:0]   Occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0]         DEPTH_O = OW'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h00000013);
  localparam logic [DATA_WIDTH-1:0] ALIGN   = ~DATA_WIDTH'(3);

  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] last_pc;
  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [OW-1:0]         count;
  logic                  valid;
  logic                  pop;
  logic                  push;

  // Handshake decode: a redirect suppresses both push and pop in its cycle.
  always_comb begin
    valid = (count != '0);
    pop   = valid && !StallF && !PCSrcE;
    push  = !PCSrcE && ((count < DEPTH_O) || pop);
  end

  // Control state: fetch address, pointers, occupancy and the last seen head PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      last_pc  <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (valid) begin
        last_pc <= pc_mem[head];
      end
      if (PCSrcE) begin
        fetch_pc <= PCTargetE & ALIGN;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + DATA_WIDTH'(4);
          tail     <= tail + PW'(1);
        end
        if (pop) begin
          head <= head + PW'(1);
        end
        if (push && !pop) begin
          count <= count + OW'(1);
        end else if (pop && !push) begin
          count <= count - OW'(1);
        end
      end
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= ImemRdata;
    end
  end

  // Head presentation: NOP while empty, PC outputs hold the last head value.
  always_comb begin
    ImemAddr  = fetch_pc;
    ValidF    = valid;
    Occupancy = count;
    PCF       = valid ? pc_mem[head] : last_pc;
    InstrF    = valid ? instr_mem[head] : NOP;
    PCPlus4F  = PCF + DATA_WIDTH'(4);
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of PC, target and instruction words.
REQ-002 Parameter DEPTH, default 4: number of fetch-queue entries; power of two, 2 to 16.
REQ-003 Parameter RESET_PC, default 32'h00000000: fetch address loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 PCTargetE  input  DATA_WIDTH  redirect target from Execute.
REQ-007 PCSrcE  input  1  redirect request from Execute (branch taken / jump).
REQ-008 StallF  input  1  hazard-unit hold; queue head is not consumed while high.
REQ-009 ImemAddr  output  DATA_WIDTH  fetch address to instruction memory (equals FetchPC).
REQ-010 ImemRdata  input  DATA_WIDTH  combinational instruction memory read data for ImemAddr.
REQ-011 InstrF  output  DATA_WIDTH  instruction at queue head.
REQ-012 PCF  output  DATA_WIDTH  PC of queue-head instruction.
REQ-013 PCPlus4F  output  DATA_WIDTH  PCF + 4, modulo 2^DATA_WIDTH.
REQ-014 ValidF  output  1  queue head holds a valid instruction.
REQ-015 Occupancy  output  clog2(DEPTH+1)  current number of valid entries.

Function
REQ-016 Internal FetchPC register drives ImemAddr; each entry stores {PC, instruction}.
REQ-017 Pop occurs in a cycle when ValidF=1 and StallF=0 and PCSrcE=0.
REQ-018 Push occurs in a cycle when PCSrcE=0 and (Occupancy<DEPTH or pop): entry {FetchPC, ImemRdata} written at tail, FetchPC <= FetchPC+4.
REQ-019 When full and no pop: no push, FetchPC holds, queue contents hold.
REQ-020 Simultaneous push and pop: Occupancy unchanged, head advances, new entry written at tail, both in the same edge.
REQ-021 Redirect (PCSrcE=1): all entries invalidated, Occupancy <= 0, FetchPC <= {PCTargetE[DATA_WIDTH-1:2], 2'b00}; no push and no pop that cycle; overrides StallF and fullness.
REQ-022 Cycle after redirect: ValidF=0; first instruction from target appears with ValidF=1 one cycle later (redirect-to-valid latency 2 edges).
REQ-023 Empty queue, no stall: fetched instruction visible at head one edge after FetchPC presents its address (fetch-to-head latency 1).
REQ-024 Head/tail pointers wrap modulo DEPTH; FetchPC and PCPlus4F wrap modulo 2^DATA_WIDTH without error.
REQ-025 InstrF, PCF, PCPlus4F driven from head entry; when ValidF=0 InstrF shall be 32'h00000013 (NOP) and PCF/PCPlus4F hold last head values.
REQ-026 Occupancy never exceeds DEPTH and never underflows below 0.

Reset
REQ-027 rst asserted asynchronously: FetchPC <= RESET_PC, Occupancy <= 0, pointers <= 0, ValidF=0, InstrF=NOP, PCF=RESET_PC, PCPlus4F=RESET_PC+4, without waiting for a clock edge.
REQ-028 Reset mid-operation discards all queued entries and any concurrent redirect.
REQ-029 First push after reset deasserts occurs on the first rising edge with rst=0.

Verification
REQ-030 Reset release, StallF=0, memory word(A)=A: ImemAddr 0,4,8,...; ValidF high from second edge; PCF=0 then 4, InstrF=PCF each cycle.
REQ-031 StallF=1 held 6 cycles, DEPTH=4: Occupancy 1,2,3,4,4,4; ImemAddr stops at 0x10; head stays PCF=0x0; release -> PCF 0x0,0x4,0x8 on consecutive cycles, no gaps.
REQ-032 Full queue, PCSrcE=1, PCTargetE=0x103: Occupancy=0, ValidF=0 next cycle; ImemAddr=0x100; PCF=0x100 valid one cycle later.
REQ-033 PCSrcE=1 with StallF=1 and queue full: redirect wins, same result as REQ-032.
REQ-034 FetchPC=0xFFFFFFFC: PCPlus4F=0x0 for that entry; next ImemAddr=0x0.
REQ-035 rst pulsed between clock edges while Occupancy=3: outputs reach reset values before next edge; no stale entry emitted afterward.
